// File: rtl/rotor_pkg.sv
// rtl/rotor_pkg.sv - Enigma rotor constants, wiring tables, notch and modular helpers
package rotor_pkg;

  localparam int ALPHA     = 26;
  localparam int CW        = 5;
  localparam int NUM_TYPES = 8;

  typedef logic [CW-1:0] code_t;
  localparam code_t       LAST_CODE = code_t'(ALPHA - 1);
  localparam logic [CW:0] ALPHA_W   = (CW+1)'(ALPHA);

  typedef enum logic [2:0] {
    ROT_I, ROT_II, ROT_III, ROT_IV, ROT_V, ROT_VI, ROT_VII, ROT_VIII
  } rotor_type_e;

  typedef enum logic [1:0] {ST_IDLE, ST_MAP, ST_OUT} state_e;

  // Forward (entry -> reflector) wiring, A=0 .. Z=25
  localparam code_t FWD_TBL [NUM_TYPES][ALPHA] = '{
    '{ 4,10,12, 5,11, 6, 3,16,21,25,13,19,14,22,24, 7,23,20,18,15, 0, 8, 1,17, 2, 9},
    '{ 0, 9, 3,10,18, 8,17,20,23, 1,11, 7,22,19,12, 2,16, 6,25,13,15,24, 5,21,14, 4},
    '{ 1, 3, 5, 7, 9,11, 2,15,17,19,23,21,25,13,24, 4, 8,22, 6, 0,10,12,20,18,16,14},
    '{ 4,18,14,21,15,25, 9, 0,24,16,20, 8,17, 7,23,11,13, 5,19, 6,10, 3, 2,12,22, 1},
    '{21,25, 1,17, 6, 8,19,24,20,15,18, 3,13, 7,11,23, 0,22,12, 9,16,14, 5, 4, 2,10},
    '{ 9,15, 6,21,14,20,12, 5,24,16, 1, 4,13, 7,25,17, 3,10, 0,18,23,11, 8, 2,19,22},
    '{13,25, 9, 7, 6,17, 2,23,12,24,18,22, 1,14,20, 5, 0, 8,21,11,15, 4,10,16, 3,19},
    '{ 5,10,16, 7,19,11,23,14, 2, 1, 9,18,15, 3,25,17, 0,12, 4,22,13, 8,20,24, 6,21}
  };

  typedef logic [1:0][NUM_TYPES-1:0][ALPHA-1:0][CW-1:0] wiring_tbl_t;

  // Index 0 is the forward table, index 1 its inverse derived from it.
  function automatic wiring_tbl_t build_tbl();
    wiring_tbl_t t;
    t = '0;
    for (int ty = 0; ty < NUM_TYPES; ty++) begin
      for (int i = 0; i < ALPHA; i++) begin
        t[0][ty][i]                = FWD_TBL[ty][i];
        t[1][ty][FWD_TBL[ty][i]]   = code_t'(i);
      end
    end
    return t;
  endfunction

  localparam wiring_tbl_t WIRING = build_tbl();

  localparam code_t NOTCH_Q = code_t'(16);
  localparam code_t NOTCH_E = code_t'(4);
  localparam code_t NOTCH_V = code_t'(21);
  localparam code_t NOTCH_J = code_t'(9);
  localparam code_t NOTCH_Z = code_t'(25);
  localparam code_t NOTCH_M = code_t'(12);

  function automatic logic is_notch(rotor_type_e ty, code_t p);
    case (ty)
      ROT_I:   return p == NOTCH_Q;
      ROT_II:  return p == NOTCH_E;
      ROT_III: return p == NOTCH_V;
      ROT_IV:  return p == NOTCH_J;
      ROT_V:   return p == NOTCH_Z;
      default: return (p == NOTCH_Z) || (p == NOTCH_M);
    endcase
  endfunction

  function automatic code_t mod_add(code_t a, code_t b);
    logic [CW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= ALPHA_W) s = s - ALPHA_W;
    return s[CW-1:0];
  endfunction

  function automatic code_t mod_sub(code_t a, code_t b);
    logic [CW:0] d;
    d = {1'b0, a} - {1'b0, b};
    if (d[CW]) d = d + ALPHA_W;
    return d[CW-1:0];
  endfunction

endpackage

// File: rtl/rotor_stage_wiring_rom.sv
// rtl/rotor_stage_wiring_rom.sv - combinational rotor wiring lookup
module rotor_wiring_rom
  import rotor_pkg::*;
(
  input  logic        dir,
  input  rotor_type_e rotor_type,
  input  code_t       idx,
  output code_t       val
);

  always_comb begin
    val = '0;
    if (idx <= LAST_CODE) val = WIRING[dir][rotor_type][idx];
  end

endmodule

// File: rtl/rotor_stage.sv
// rtl/rotor_stage.sv - Enigma rotor stage: stepping, notch carry, handshaked encipher (ROTOR_RING_EN)
module rotor_stage
  import rotor_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          cfg_load,
  input  logic [2:0]    cfg_type,
  input  logic [CW-1:0] cfg_pos,
  input  logic [CW-1:0] cfg_ring,
  input  logic          step_in,
  output logic          step_out,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [CW-1:0] in_code,
  input  logic          in_dir,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_code,
  output logic [CW-1:0] pos
);

  state_e      state, state_nxt;
  rotor_type_e rtype;
  code_t       pos_q, e_q, out_code_q, entry_idx, exit_code, rom_val;
  logic        dir_q, bypass_q, step_out_q;

`ifdef ROTOR_RING_EN
  code_t ring_q;
  assign entry_idx = mod_sub(mod_add(in_code, pos_q), ring_q);
  assign exit_code = mod_add(mod_sub(rom_val, pos_q), ring_q);
`else
  logic ring_unused;
  assign ring_unused = ^cfg_ring;
  assign entry_idx   = mod_add(in_code, pos_q);
  assign exit_code   = mod_sub(rom_val, pos_q);
`endif

  rotor_wiring_rom u_rom (
    .dir        (dir_q),
    .rotor_type (rtype),
    .idx        (e_q),
    .val        (rom_val)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (in_valid && in_ready) state_nxt = ST_MAP;
      ST_MAP:  state_nxt = ST_OUT;
      ST_OUT:  if (out_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == ST_IDLE) && !cfg_load && !step_in;
    out_valid = (state == ST_OUT);
  end

  // cfg_load outranks step_in, which outranks a data accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      rtype      <= ROT_I;
      pos_q      <= '0;
      e_q        <= '0;
      dir_q      <= 1'b0;
      bypass_q   <= 1'b0;
      out_code_q <= '0;
      step_out_q <= 1'b0;
`ifdef ROTOR_RING_EN
      ring_q     <= '0;
`endif
    end else begin
      step_out_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cfg_load) begin
            rtype  <= rotor_type_e'(cfg_type);
            pos_q  <= (cfg_pos <= LAST_CODE) ? cfg_pos : '0;
`ifdef ROTOR_RING_EN
            ring_q <= (cfg_ring <= LAST_CODE) ? cfg_ring : '0;
`endif
          end else if (step_in) begin
            pos_q      <= (pos_q == LAST_CODE) ? '0 : pos_q + 1'b1;
            step_out_q <= is_notch(rtype, pos_q);
          end else if (in_valid) begin
            bypass_q <= (in_code > LAST_CODE);
            e_q      <= (in_code > LAST_CODE) ? in_code : entry_idx;
            dir_q    <= in_dir;
          end
        end
        ST_MAP:  out_code_q <= bypass_q ? e_q : exit_code;
        default: ;
      endcase
    end
  end

  assign step_out = step_out_q;
  assign out_code = out_code_q;
  assign pos      = pos_q;

endmodule
